// File: rtl/bus_regfile.sv
// Register file on a shared tristate bus with in-place increment/decrement/shift ops
// and registered zero/negative/carry flags.
module bus_regfile #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DEPTH = 4,
   parameter int unsigned AW    = 2
) (
   input  logic          clk,
   input  logic          clr,
   inout  wire [WIDTH-1:0] bus,
   input  logic          wa,
   input  logic          oa,
   input  logic [AW-1:0] waddr,
   input  logic [AW-1:0] raddr,
   input  logic [1:0]    op,
   output logic          z,
   output logic          n,
   output logic          c
);

   logic [WIDTH-1:0] regs_q [DEPTH];
   logic [WIDTH-1:0] regs_d [DEPTH];
   logic             z_q, z_d;
   logic             n_q, n_d;
   logic             c_q, c_d;

   logic [WIDTH-1:0] rd_data;
   logic [WIDTH-1:0] wr_data;
   logic [WIDTH-1:0] cur;
   logic [WIDTH-1:0] op_res;
   logic             op_c;
   logic [WIDTH-1:0] new_val;

   assign rd_data = regs_q[raddr];
   assign bus     = (oa && !clr) ? rd_data : 'z;

   // Internal transfer takes the register directly rather than the resolved bus.
   assign wr_data = oa ? rd_data : bus;
   assign cur     = regs_q[waddr];

   always_comb begin
      op_res = cur;
      op_c   = 1'b0;
      case (op)
         2'b01:   {op_c, op_res} = {1'b0, cur} + (WIDTH+1)'(1);
         2'b10:   {op_c, op_res} = {1'b0, cur} - (WIDTH+1)'(1);
         2'b11:   {op_c, op_res} = {cur, 1'b0};
         default: begin
            op_res = cur;
            op_c   = 1'b0;
         end
      endcase
   end

   assign new_val = wa ? wr_data : op_res;

   always_comb begin
      regs_d = regs_q;
      z_d    = z_q;
      n_d    = n_q;
      c_d    = c_q;
      if (wa || (op != 2'b00)) begin
         regs_d[waddr] = new_val;
         z_d           = (new_val == '0);
         n_d           = new_val[WIDTH-1];
         c_d           = wa ? 1'b0 : op_c;
      end
   end

   always_ff @(posedge clk) begin
      if (clr) begin
         for (int unsigned i = 0; i < DEPTH; i++) begin
            regs_q[i] <= '0;
         end
         z_q <= 1'b1;
         n_q <= 1'b0;
         c_q <= 1'b0;
      end else begin
         regs_q <= regs_d;
         z_q    <= z_d;
         n_q    <= n_d;
         c_q    <= c_d;
      end
   end

   assign z = z_q;
   assign n = n_q;
   assign c = c_q;

endmodule
